// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with one outstanding IMEM read, timeout and halt.
// Ports: CLK/RST_F, controller FETCH/PC_*/BR_SEL, IMEM_* handshake, IR/PC/status outputs.
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              FETCH,
  input  logic              PC_WRITE,
  input  logic              PC_SEL,
  input  logic              BR_SEL,
  input  logic              PC_RST,
  input  logic              IMEM_ACK,
  input  logic [31:0]       IMEM_DATA,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [3:0]        OPCODE,
  output logic [3:0]        MM,
  output logic [31:0]       IR_OUT,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              IR_VALID,
  output logic              BUSY,
  output logic              FETCH_ERR,
  output logic              HALTED
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_upd;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       ir;
  logic [31:0]       ir_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic              err;
  logic              err_d;
  logic              halt;
  logic              halt_d;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      pc   <= '0;
      ir   <= '0;
      addr <= '0;
      cnt  <= '0;
      err  <= 1'b0;
      halt <= 1'b0;
    end else begin
      pc   <= pc_d;
      ir   <= ir_d;
      addr <= addr_d;
      cnt  <= cnt_d;
      err  <= err_d;
      halt <= halt_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    ir_d    = ir;
    addr_d  = addr;
    cnt_d   = cnt;
    err_d   = err;
    halt_d  = halt;
    // Sign-extend IR[15:0] into the PC width.
    for (int i = 0; i < ADDR_W; i++)
      off[i] = ir[(i < 16) ? i : 15];
    tgt    = BR_SEL ? ir[ADDR_W-1:0] : pc + off;
    pc_upd = (PC_WRITE && PC_SEL) ? tgt : pc;
    pc_nx  = PC_RST ? '0 : pc_upd;
    unique case (state)
      IDLE: begin
        pc_d = pc_nx;
        if (FETCH && !halt) begin
          state_d = REQ;
          addr_d  = pc_nx;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          pc_d    = pc + ADDR_W'(1);
          state_d = DONE;
          if (IMEM_DATA[31:28] == 4'hF) halt_d = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE: begin
        pc_d    = pc_nx;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Synchronous clear wins over branch load and increment.
    if (PC_RST) pc_d = '0;
  end

  assign IMEM_REQ  = (state == REQ);
  assign IMEM_ADDR = addr;
  assign IR_VALID  = (state == DONE);
  assign BUSY      = (state != IDLE);
  assign OPCODE    = ir[31:28];
  assign MM        = ir[27:24];
  assign IR_OUT    = ir;
  assign PC_OUT    = pc;
  assign FETCH_ERR = err;
  assign HALTED    = halt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for fetch_unit.
// Covers fetch latency, branches, wrap, PC_RST, timeout, halt and async reset.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_F;
  logic        FETCH, PC_WRITE, PC_SEL, BR_SEL, PC_RST, IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic [3:0]  OPCODE, MM;
  logic [31:0] IR_OUT;
  logic [15:0] PC_OUT;
  logic        IR_VALID, BUSY, FETCH_ERR, HALTED;

  int nvec = 0;
  int nmis = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.ADDR_W(16), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST_F(RST_F), .FETCH(FETCH),
    .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL), .BR_SEL(BR_SEL),
    .PC_RST(PC_RST), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .OPCODE(OPCODE), .MM(MM), .IR_OUT(IR_OUT), .PC_OUT(PC_OUT),
    .IR_VALID(IR_VALID), .BUSY(BUSY),
    .FETCH_ERR(FETCH_ERR), .HALTED(HALTED)
  );

  typedef struct {
    logic        f, pw, ps, bs, pr, ack;
    logic [31:0] data;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic f, pw, ps, bs, pr, ack,
    input logic [31:0] data,
    input logic req, input logic [15:0] addr,
    input logic vld, input logic [15:0] pc,
    input logic [31:0] ir, input logic busy);
    vec_t v;
    v.f = f; v.pw = pw; v.ps = ps; v.bs = bs; v.pr = pr;
    v.ack = ack; v.data = data; v.req = req; v.addr = addr;
    v.vld = vld; v.pc = pc; v.ir = ir; v.busy = busy;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    FETCH = 0; PC_WRITE = 0; PC_SEL = 0; BR_SEL = 0;
    PC_RST = 0; IMEM_ACK = 0; IMEM_DATA = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    RST_F = 0;
    // reset
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 1,16'h0,0,16'h0,32'h0,1));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 1,16'h0,0,16'h0,32'h0,1));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 1,16'h0,0,16'h0,32'h0,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h81000005,
                      0,16'h0,1,16'h1,32'h81000005,1));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 0,16'h0,0,16'h1,32'h81000005,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'h12345678,
                      0,16'h0,0,16'h1,32'h81000005,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 1,16'h1,0,16'h1,32'h81000005,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0000000F,
                      0,16'h1,1,16'h2,32'h0000000F,1));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0, 0,16'h1,0,16'hF,32'h0000000F,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 1,16'hF,0,16'hF,32'h0000000F,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h40000020,
                      0,16'hF,1,16'h10,32'h40000020,1));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0,
                      0,16'hF,0,16'h20,32'h40000020,0));
    vecs.push_back(mk(1,1,1,0,0,0,32'h0,
                      1,16'h40,0,16'h40,32'h40000020,1));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0,
                      1,16'h40,0,16'h40,32'h40000020,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h0000000F,
                      0,16'h40,1,16'h41,32'h0000000F,1));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0, 0,16'h40,0,16'hF,32'h0000000F,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 1,16'hF,0,16'hF,32'h0000000F,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h5000FFFE,
                      0,16'hF,1,16'h10,32'h5000FFFE,1));
    vecs.push_back(mk(0,1,1,0,0,0,32'h0, 0,16'hF,0,16'hE,32'h5000FFFE,0));
    vecs.push_back(mk(0,1,0,1,0,0,32'h0, 0,16'hF,0,16'hE,32'h5000FFFE,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 1,16'hE,0,16'hE,32'h5000FFFE,1));
    vecs.push_back(mk(1,0,0,0,0,1,32'h0000FFFF,
                      0,16'hE,1,16'hF,32'h0000FFFF,1));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 0,16'hE,0,16'hF,32'h0000FFFF,0));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0,
                      0,16'hE,0,16'hFFFF,32'h0000FFFF,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,
                      1,16'hFFFF,0,16'hFFFF,32'h0000FFFF,1));
    vecs.push_back(mk(0,0,0,0,0,1,32'h00000003,
                      0,16'hFFFF,1,16'h0,32'h00000003,1));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0,
                      0,16'hFFFF,0,16'h3,32'h00000003,0));
    vecs.push_back(mk(0,1,1,1,1,0,32'h0,
                      0,16'hFFFF,0,16'h0,32'h00000003,0));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0, 1,16'h0,0,16'h0,32'h00000003,1));
    vecs.push_back(mk(0,0,0,0,1,1,32'h00000007,
                      0,16'h0,1,16'h0,32'h00000007,1));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0, 0,16'h0,0,16'h0,32'h00000007,0));

    tick();
    chk("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    chk("rst_addr", {16'd0, IMEM_ADDR}, 32'd0);
    chk("rst_pc", {16'd0, PC_OUT}, 32'd0);
    chk("rst_ir", IR_OUT, 32'd0);
    chk("rst_flags", {28'd0, IR_VALID, BUSY, FETCH_ERR, HALTED}, 32'd0);
    RST_F = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic ok;
      v = vecs[i];
      FETCH = v.f; PC_WRITE = v.pw; PC_SEL = v.ps; BR_SEL = v.bs;
      PC_RST = v.pr; IMEM_ACK = v.ack; IMEM_DATA = v.data;
      tick();
      ok = (IMEM_REQ === v.req) && (IMEM_ADDR === v.addr) &&
           (IR_VALID === v.vld) && (PC_OUT === v.pc) &&
           (IR_OUT === v.ir) && (BUSY === v.busy) &&
           (FETCH_ERR === 1'b0) && (HALTED === 1'b0) &&
           (OPCODE === v.ir[31:28]) && (MM === v.ir[27:24]);
      nvec++;
      if (!ok) begin
        nmis++;
        $display("FAIL vec%0d: got req=%b addr=%h vld=%b pc=%h ir=%h busy=%b err=%b halt=%b op=%h mm=%h; want req=%b addr=%h vld=%b pc=%h ir=%h busy=%b err=0 halt=0",
                 i, IMEM_REQ, IMEM_ADDR, IR_VALID, PC_OUT, IR_OUT, BUSY,
                 FETCH_ERR, HALTED, OPCODE, MM, v.req, v.addr, v.vld,
                 v.pc, v.ir, v.busy);
      end
    end
    quiet();

    // Timeout: 16 REQ cycles without ACK.
    FETCH = 1;
    tick();
    FETCH = 0;
    chk("to_req", {31'd0, IMEM_REQ}, 32'd1);
    for (int k = 1; k < 16; k++) tick();
    chk("to_hold_req", {31'd0, IMEM_REQ}, 32'd1);
    chk("to_hold_addr", {16'd0, IMEM_ADDR}, 32'd0);
    chk("to_hold_err", {31'd0, FETCH_ERR}, 32'd0);
    tick();
    chk("to_req_drop", {31'd0, IMEM_REQ}, 32'd0);
    chk("to_err", {31'd0, FETCH_ERR}, 32'd1);
    chk("to_pc", {16'd0, PC_OUT}, 32'd0);
    chk("to_ir", IR_OUT, 32'h7);
    chk("to_vld_busy", {30'd0, IR_VALID, BUSY}, 32'd0);
    IMEM_ACK = 1; IMEM_DATA = 32'hF000_0000;
    tick();
    quiet();
    chk("late_ack_ir", IR_OUT, 32'h7);
    chk("late_ack_flags", {30'd0, IR_VALID, HALTED}, 32'd0);

    // Halt instruction.
    FETCH = 1;
    tick();
    FETCH = 0; IMEM_ACK = 1; IMEM_DATA = 32'hF000_0000;
    tick();
    quiet();
    chk("halt_ir", IR_OUT, 32'hF000_0000);
    chk("halt_flag", {31'd0, HALTED}, 32'd1);
    chk("halt_pc", {16'd0, PC_OUT}, 32'd1);
    tick();
    FETCH = 1;
    tick();
    FETCH = 0;
    chk("halt_nofetch", {30'd0, IMEM_REQ, BUSY}, 32'd0);
    chk("err_sticky", {31'd0, FETCH_ERR}, 32'd1);

    // Asynchronous reset clears sticky flags.
    RST_F = 0;
    #1;
    chk("rst2_flags", {28'd0, IR_VALID, BUSY, FETCH_ERR, HALTED}, 32'd0);
    chk("rst2_pc", {16'd0, PC_OUT}, 32'd0);
    chk("rst2_ir", IR_OUT, 32'd0);
    RST_F = 1;
    FETCH = 1;
    tick();
    FETCH = 0;
    chk("post_rst_req", {31'd0, IMEM_REQ}, 32'd1);
    chk("post_rst_addr", {16'd0, IMEM_ADDR}, 32'd0);
    tick();
    #3;
    RST_F = 0;
    #1;
    chk("mid_rst_req", {30'd0, IMEM_REQ, BUSY}, 32'd0);
    chk("mid_rst_addr", {16'd0, IMEM_ADDR}, 32'd0);
    #1;
    RST_F = 1;
    IMEM_ACK = 1; IMEM_DATA = 32'h8100_0005;
    tick();
    quiet();
    chk("mid_rst_ack_ir", IR_OUT, 32'd0);
    chk("mid_rst_ack_vld", {30'd0, IR_VALID, BUSY}, 32'd0);
    chk("mid_rst_ack_pc", {16'd0, PC_OUT}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
